obi_mailbox_resp: RTL and testbench

OBI_MAILBOX_RESP -- requirements
Module: obi_mailbox_resp

---
 rtl/obi_mailbox_resp.sv | 140 ++++++++++++++
 tb/tb_obi_mailbox_resp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/obi_mailbox_resp.sv
// OBI target mailbox: a DATA push FIFO drained by the host, a sticky STATUS word, and a host-loaded CMD register.
// Optional OBI_MAILBOX_ERR_EN adds err_o for unmapped accesses and for pushes dropped because the FIFO was full.
module obi_mailbox_resp #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
`ifdef OBI_MAILBOX_ERR_EN
  output logic        err_o,
`endif
  output logic [31:0] host_data_o,
  output logic        host_valid_o,
  input  logic        host_pop_i,
  input  logic [31:0] host_cmd_i,
  input  logic        host_cmd_we_i,
  output logic        host_cmd_pending_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, RESP} state_e;
  typedef enum logic [1:0] {OFF_DATA, OFF_STATUS, OFF_CMD, OFF_UNMAPPED} offset_e;

  state_e        state_q, state_d;
  offset_e       offset;
  logic          granted, push_req, push_ok, push_drop, pop, full;
  logic [31:0]   wdata_masked, rdata_d, rdata_q, cmd_q;
  logic          overflow_q, cmd_pending_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem [DEPTH];
  logic          unused_addr;

  assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};
  assign offset      = offset_e'(addr_i[3:2]);

  // Response FSM: grant only from IDLE, so at most one transaction every two cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign granted   = req_i && gnt_o;
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = host_pop_i && host_valid_o;
  assign push_req  = granted && we_i && (offset == OFF_DATA);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && !push_ok;

  always_comb begin
    for (int i = 0; i < 4; i++) wdata_masked[8*i +: 8] = be_i[i] ? wdata_i[8*i +: 8] : 8'h00;
  end

  always_comb begin
    rdata_d = '0;
    if (granted && !we_i) begin
      unique case (offset)
        OFF_STATUS: rdata_d = {overflow_q, cmd_pending_q, 14'b0, 16'(count_q)};
        OFF_CMD:    rdata_d = cmd_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      cmd_q         <= '0;
      cmd_pending_q <= 1'b0;
    end else begin
      // Not granted means no response next cycle, so rdata returns to zero.
      rdata_q <= rdata_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push_drop)                                          overflow_q <= 1'b1;
      else if (granted && !we_i && offset == OFF_STATUS)      overflow_q <= 1'b0;
      if (host_cmd_we_i) begin
        cmd_q         <= host_cmd_i;
        cmd_pending_q <= 1'b1;
      end else if (granted && !we_i && offset == OFF_CMD) begin
        cmd_pending_q <= 1'b0;
      end
    end
  end

  // NOTE: storage is not reset; the pointers and count define what is valid, so stale words are never visible.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= wdata_masked;
  end

`ifdef OBI_MAILBOX_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= granted && ((offset == OFF_UNMAPPED) || push_drop);
  end
  assign err_o = err_q;
`endif

  assign rvalid_o           = (state_q == RESP);
  assign rdata_o            = rdata_q;
  assign host_valid_o       = (count_q != '0);
  assign host_data_o        = mem[rd_ptr_q];
  assign host_cmd_pending_o = cmd_pending_q;

endmodule

// File: tb/tb_obi_mailbox_resp.sv
// Self-checking bench for obi_mailbox_resp: directed scenarios then randomized traffic against a queue-based model.
module tb_obi_mailbox_resp;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, host_pop_i = 1'b0, host_cmd_we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0, host_cmd_i = '0;
  logic        gnt_o, rvalid_o, host_valid_o, host_cmd_pending_o;
  logic [31:0] rdata_o, host_data_o;
`ifdef OBI_MAILBOX_ERR_EN
  logic        err_o;
`endif

  obi_mailbox_resp #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
`ifdef OBI_MAILBOX_ERR_EN
    .err_o(err_o),
`endif
    .host_data_o(host_data_o), .host_valid_o(host_valid_o), .host_pop_i(host_pop_i),
    .host_cmd_i(host_cmd_i), .host_cmd_we_i(host_cmd_we_i), .host_cmd_pending_o(host_cmd_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: mailbox contents as a queue, flags as plain bits.
  logic [31:0] mq[$];
  bit          m_ovf, m_pend, m_resp, m_err;
  logic [31:0] m_cmd, m_rdata, last_rdata;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_pend = 0; m_resp = 0; m_err = 0;
    m_cmd = '0; m_rdata = '0;
  endtask

  // One clock cycle: drive at posedge+1, check grant, model the edge, check registered outputs at posedge+1.
  task automatic step(input bit req, input bit we, input logic [1:0] off, input logic [3:0] be,
                      input logic [31:0] wd, input bit pop, input bit cmd_we, input logic [31:0] cmd);
    bit          g, push, drop, popped;
    logic [31:0] rd, masked;
    req_i = req; we_i = we; addr_i = {$urandom_range(0, 65535), 12'h0, off, 2'b00};
    be_i = be; wdata_i = wd; host_pop_i = pop; host_cmd_we_i = cmd_we; host_cmd_i = cmd;
    #1;
    g = req && !m_resp;
    check("gnt", 32'(gnt_o), 32'(g));
    rd = '0;
    if (g && !we && off == 2'd1) rd = {m_ovf, m_pend, 14'b0, 16'(mq.size())};
    if (g && !we && off == 2'd2) rd = m_cmd;
    for (int i = 0; i < 4; i++) masked[8*i +: 8] = be[i] ? wd[8*i +: 8] : 8'h00;
    push = g && we && off == 2'd0;
    popped = pop && mq.size() > 0;
    if (popped) void'(mq.pop_front());
    drop = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(masked);
      else begin drop = 1; m_ovf = 1; end
    end
    if (g && !we && off == 2'd1) m_ovf = 0;
    if (cmd_we) begin m_cmd = cmd; m_pend = 1; end
    else if (g && !we && off == 2'd2) m_pend = 0;
    m_resp  = g;
    m_rdata = rd;
    m_err   = g && (off == 2'd3 || drop);
    @(posedge clk_i);
    #1;
    check("rvalid", 32'(rvalid_o), 32'(m_resp));
    check("rdata", rdata_o, m_rdata);
`ifdef OBI_MAILBOX_ERR_EN
    if (m_resp) check("err", 32'(err_o), 32'(m_err));
`endif
    check("host_valid", 32'(host_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) check("host_data", host_data_o, mq[0]);
    check("cmd_pending", 32'(host_cmd_pending_o), 32'(m_pend));
  endtask

  task automatic idle(input bit pop);
    step(0, 0, 2'd0, 4'h0, 32'h0, pop, 0, 32'h0);
  endtask

  task automatic obi(input bit we, input logic [1:0] off, input logic [3:0] be, input logic [31:0] wd);
    step(1, we, off, be, wd, 0, 0, 32'h0);
    last_rdata = rdata_o;
    idle(0);
  endtask

  initial begin
    model_reset();
    // Reset state: grant is combinational even while held in reset.
    req_i = 1'b1;
    #2;
    check("rst_gnt", 32'(gnt_o), 32'h1);
    check("rst_rvalid", 32'(rvalid_o), 32'h0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_host_valid", 32'(host_valid_o), 32'h0);
    check("rst_pending", 32'(host_cmd_pending_o), 32'h0);
    req_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Full-word and byte-masked pushes.
    step(1, 1, 2'd0, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0);
    check("write_rvalid", 32'(rvalid_o), 32'h1);
    check("write_head", host_data_o, 32'hDEADBEEF);
    idle(1);
    obi(1, 2'd0, 4'h5, 32'h11223344);
    check("masked_head", host_data_o, 32'h00220044);
    idle(1);

    // Overflow is sticky until one STATUS read.
    for (int i = 0; i < 5; i++) obi(1, 2'd0, 4'hF, 32'h100 + i);
    obi(0, 2'd1, 4'hF, 32'h0);
    check("status_ovf", last_rdata, 32'h80000004);
    obi(0, 2'd1, 4'hF, 32'h0);
    check("status_clr", last_rdata, 32'h00000004);

    // Push into a full FIFO with a simultaneous pop is accepted.
    step(1, 1, 2'd0, 4'hF, 32'hA5A5A5A5, 1, 0, 32'h0);
    idle(0);
    obi(0, 2'd1, 4'hF, 32'h0);
    check("full_pop_status", last_rdata, 32'h00000004);
    for (int i = 0; i < 3; i++) idle(1);
    check("last_popped", host_data_o, 32'hA5A5A5A5);
    idle(1);

    // Command register handshake, including a load that races a CMD read.
    step(0, 0, 2'd0, 4'h0, 32'h0, 0, 1, 32'h00000042);
    check("cmd_pending_set", 32'(host_cmd_pending_o), 32'h1);
    obi(0, 2'd1, 4'hF, 32'h0);
    check("status_bit30", 32'(last_rdata[30]), 32'h1);
    obi(0, 2'd2, 4'hF, 32'h0);
    check("cmd_read", last_rdata, 32'h00000042);
    check("cmd_pending_clr", 32'(host_cmd_pending_o), 32'h0);
    step(1, 0, 2'd2, 4'hF, 32'h0, 0, 1, 32'h00000099);
    check("cmd_race_old", rdata_o, 32'h00000042);
    check("cmd_race_pending", 32'(host_cmd_pending_o), 32'h1);
    idle(0);

    // Back-to-back requests alternate grant and response.
    for (int i = 0; i < 6; i++) step(1, 0, 2'd1, 4'hF, 32'h0, 0, 0, 32'h0);

    // Reset during RESP cancels the response and empties everything.
    obi(1, 2'd0, 4'hF, 32'h12345678);
    step(1, 0, 2'd1, 4'hF, 32'h0, 0, 0, 32'h0);
    #2;
    rst_ni = 1'b0;
    req_i  = 1'b0;
    #1;
    model_reset();
    check("midrst_rvalid", 32'(rvalid_o), 32'h0);
    check("midrst_rdata", rdata_o, 32'h0);
    check("midrst_host_valid", 32'(host_valid_o), 32'h0);
    check("midrst_pending", 32'(host_cmd_pending_o), 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_rvalid", 32'(rvalid_o), 32'h0);

    // Randomized traffic, biased toward DATA writes so the FIFO fills and overflows.
    for (int n = 0; n < 3000; n++) begin
      bit          req, we, pop, cmd_we;
      logic [1:0]  off;
      req    = ($urandom_range(0, 9) < 7);
      we     = ($urandom_range(0, 1) == 1);
      off    = 2'($urandom_range(0, 3));
      if (we && $urandom_range(0, 9) < 7) off = 2'd0;
      pop    = ($urandom_range(0, 2) == 0);
      cmd_we = ($urandom_range(0, 7) == 0);
      step(req, we, off, 4'($urandom_range(0, 15)), $urandom, pop, cmd_we, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
